mem_arbiter: RTL and testbench

Two-requester arbiter sharing the single-port, unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (loads/stores) of the pipelined datapath. It muxes one request per cycle onto the memory's `mem_write`/`address`/`write_data` inputs. It routes the memory's registered `read_data` back to the requester that issued the read, one cycle later. It exports per-requester grants that the hazard unit uses as stall conditions.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_starve_cnt.sv | 38 +++
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory IF/MEM arbiter.
// Response-owner encoding doubles as the response FSM state encoding.
package mem_arb_pkg;

    localparam logic [1:0] OWNER_NONE = 2'd0;
    localparam logic [1:0] OWNER_IF   = 2'd1;
    localparam logic [1:0] OWNER_DM   = 2'd2;

    localparam int STARVE_LIMIT_DEFAULT = 4;

    typedef enum logic [1:0] {
        RESP_NONE = OWNER_NONE,
        RESP_IF   = OWNER_IF,
        RESP_DM   = OWNER_DM
    } resp_state_t;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of consecutive denied fetch cycles; flags when fetch must win.
// Only instantiated when MEM_ARB_STARVE_GUARD_EN is defined.
module mem_arb_starve_cnt #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic if_gnt,
    output logic starve_hit
);

    localparam int CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_VAL = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (!if_req || if_gnt) begin
            cnt_next = '0;
        end else if (cnt_reg != LIMIT_VAL) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign starve_hit = (cnt_reg == LIMIT_VAL);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and data access.
// Define MEM_ARB_STARVE_GUARD_EN to let a starved fetch override data priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int address_bits = 32,
    parameter int data_width   = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req,
    input  logic [address_bits-1:0] if_addr,
    output logic                    if_gnt,
    output logic                    if_rvalid,
    output logic [data_width-1:0]   if_rdata,
    input  logic                    dm_req,
    input  logic                    dm_we,
    input  logic [address_bits-1:0] dm_addr,
    input  logic [data_width-1:0]   dm_wdata,
    output logic                    dm_gnt,
    output logic                    dm_rvalid,
    output logic [data_width-1:0]   dm_rdata,
    output logic                    mem_write,
    output logic [address_bits-1:0] mem_address,
    output logic [data_width-1:0]   mem_write_data,
    input  logic [data_width-1:0]   mem_read_data
);

    resp_state_t             resp_state_reg;
    resp_state_t             resp_state_next;
    logic [address_bits-1:0] last_addr_reg;
    logic                    force_if;

`ifdef MEM_ARB_STARVE_GUARD_EN
    mem_arb_starve_cnt #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve_cnt (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_gnt    (if_gnt),
        .starve_hit(force_if)
    );
`else
    assign force_if = 1'b0;
`endif

    // Data wins by default; a saturated starvation count hands one contention to fetch.
    always_comb begin
        dm_gnt = 1'b0;
        if_gnt = 1'b0;
        if (!rst) begin
            if (dm_req && !(force_if && if_req)) begin
                dm_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    // Address holds its last granted value on idle cycles so the memory sees no glitch.
    always_comb begin
        mem_address = last_addr_reg;
        if (dm_gnt) begin
            mem_address = dm_addr;
        end else if (if_gnt) begin
            mem_address = if_addr;
        end
    end

    assign mem_write      = dm_gnt & dm_we;
    assign mem_write_data = dm_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_addr_reg  <= '0;
            resp_state_reg <= RESP_NONE;
        end else begin
            if (if_gnt || dm_gnt) begin
                last_addr_reg <= mem_address;
            end
            resp_state_reg <= resp_state_next;
        end
    end

    always_comb begin
        resp_state_next = RESP_NONE;
        if_rvalid       = 1'b0;
        dm_rvalid       = 1'b0;
        if_rdata        = '0;
        dm_rdata        = '0;

        if (if_gnt) begin
            resp_state_next = RESP_IF;
        end else if (dm_gnt && !dm_we) begin
            resp_state_next = RESP_DM;
        end

        case (resp_state_reg)
            RESP_IF: begin
                if_rvalid = 1'b1;
                if_rdata  = mem_read_data;
            end
            RESP_DM: begin
                dm_rvalid = 1'b1;
                dm_rdata  = mem_read_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a registered-read memory model.
// Starvation expectations follow MEM_ARB_STARVE_GUARD_EN.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    // Memory: word-addressed, write on edge, registered read (old data on same-edge write).
    always @(posedge clk) begin
        if (mem_write) mem[mem_address[9:2]] <= mem_write_data;
        mem_read_data <= mem[mem_address[9:2]];
    end

    mem_arbiter #(
        .address_bits(32),
        .data_width  (32),
        .STARVE_LIMIT(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_gnt        (if_gnt),
        .if_rvalid     (if_rvalid),
        .if_rdata      (if_rdata),
        .dm_req        (dm_req),
        .dm_we         (dm_we),
        .dm_addr       (dm_addr),
        .dm_wdata      (dm_wdata),
        .dm_gnt        (dm_gnt),
        .dm_rvalid     (dm_rvalid),
        .dm_rdata      (dm_rdata),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_write_data(mem_write_data),
        .mem_read_data (mem_read_data)
    );

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; if_req = 1'b1; if_addr = 32'h10;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h44; dm_wdata = 32'h1234_5678;
        #1;
        tests_run++;
        if ({if_gnt, dm_gnt, mem_write} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_gnts: got if_gnt=%b dm_gnt=%b mem_write=%b, want 000", if_gnt, dm_gnt, mem_write);
        end
        tests_run++;
        if ({if_rvalid, dm_rvalid, if_rdata, dm_rdata, mem_address} !== 98'd0) begin
            tests_failed++;
            $display("FAIL reset_outs: got rvalid=%b%b if_rdata=%h dm_rdata=%h addr=%h, want all 0",
                     if_rvalid, dm_rvalid, if_rdata, dm_rdata, mem_address);
        end
        @(negedge clk);
        rst = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        #1;
        $display("[TB] reset release: fetch 0x10");
        tests_run++;
        if (if_gnt !== 1'b1 || mem_address !== 32'h10) begin
            tests_failed++;
            $display("FAIL release_gnt: got if_gnt=%b addr=%h, want 1 00000010", if_gnt, mem_address);
        end
        @(posedge clk); #1;
        tests_run++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'hA000_0010) begin
            tests_failed++;
            $display("FAIL release_rdata: got if_rvalid=%b if_rdata=%h, want 1 a0000010", if_rvalid, if_rdata);
        end
        @(negedge clk);
        if_req = 1'b0;
    endtask

    task automatic test_store_load();
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF;
        #1;
        $display("[TB] store 0x40 <= deadbeef");
        tests_run++;
        if (dm_gnt !== 1'b1 || mem_write !== 1'b1 || if_gnt !== 1'b0 || mem_write_data !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL store_gnt: got dm_gnt=%b mem_write=%b if_gnt=%b wdata=%h, want 1 1 0 deadbeef",
                     dm_gnt, mem_write, if_gnt, mem_write_data);
        end
        @(posedge clk); #1;
        tests_run++;
        if (dm_rvalid !== 1'b0 || dm_rdata !== 32'd0) begin
            tests_failed++;
            $display("FAIL store_no_rvalid: got dm_rvalid=%b dm_rdata=%h, want 0 00000000", dm_rvalid, dm_rdata);
        end
        @(negedge clk);
        dm_we = 1'b0;
        #1;
        $display("[TB] load 0x40");
        tests_run++;
        if (dm_gnt !== 1'b1 || mem_write !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_gnt: got dm_gnt=%b mem_write=%b, want 1 0", dm_gnt, mem_write);
        end
        @(posedge clk); #1;
        tests_run++;
        if (dm_rvalid !== 1'b1 || dm_rdata !== 32'hDEAD_BEEF || if_rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_rdata: got dm_rvalid=%b dm_rdata=%h if_rvalid=%b, want 1 deadbeef 0",
                     dm_rvalid, dm_rdata, if_rvalid);
        end
        @(negedge clk);
        dm_req = 1'b0;
    endtask

    task automatic test_contention();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
        #1;
        $display("[TB] contention: fetch 0x0 vs load 0x80");
        tests_run++;
        if (dm_gnt !== 1'b1 || if_gnt !== 1'b0 || mem_address !== 32'h80) begin
            tests_failed++;
            $display("FAIL cont_c0: got dm_gnt=%b if_gnt=%b addr=%h, want 1 0 00000080", dm_gnt, if_gnt, mem_address);
        end
        @(posedge clk); #1;
        tests_run++;
        if (dm_rvalid !== 1'b1 || dm_rdata !== 32'hA000_0080) begin
            tests_failed++;
            $display("FAIL cont_c1_dm: got dm_rvalid=%b dm_rdata=%h, want 1 a0000080", dm_rvalid, dm_rdata);
        end
        @(negedge clk);
        dm_req = 1'b0;
        #1;
        tests_run++;
        if (if_gnt !== 1'b1 || dm_gnt !== 1'b0 || mem_address !== 32'h0) begin
            tests_failed++;
            $display("FAIL cont_c1_gnt: got if_gnt=%b dm_gnt=%b addr=%h, want 1 0 00000000", if_gnt, dm_gnt, mem_address);
        end
        @(posedge clk); #1;
        tests_run++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'hA000_0000 || dm_rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL cont_c2: got if_rvalid=%b if_rdata=%h dm_rvalid=%b, want 1 a0000000 0",
                     if_rvalid, if_rdata, dm_rvalid);
        end
        @(negedge clk);
        if_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_word;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if_req = 1'b1; if_addr = 32'(i * 4);
            exp_word = 32'hA000_0000 + 32'(i * 4);
            #1;
            $display("[TB] back-to-back fetch 0x%0h", if_addr);
            tests_run++;
            if (if_gnt !== 1'b1) begin
                tests_failed++;
                $display("FAIL b2b_gnt%0d: got if_gnt=%b, want 1", i, if_gnt);
            end
            @(posedge clk); #1;
            tests_run++;
            if (if_rvalid !== 1'b1 || if_rdata !== exp_word) begin
                tests_failed++;
                $display("FAIL b2b_rdata%0d: got if_rvalid=%b if_rdata=%h, want 1 %h", i, if_rvalid, if_rdata, exp_word);
            end
        end
        @(negedge clk);
        if_req = 1'b0; if_addr = 32'h100;
        #1;
        tests_run++;
        if (mem_address !== 32'h8 || mem_write !== 1'b0 || if_gnt !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_hold: got addr=%h mem_write=%b if_gnt=%b, want 00000008 0 0", mem_address, mem_write, if_gnt);
        end
        @(posedge clk); #1;
        tests_run++;
        if (if_rvalid !== 1'b0 || if_rdata !== 32'd0) begin
            tests_failed++;
            $display("FAIL idle_rvalid: got if_rvalid=%b if_rdata=%h, want 0 00000000", if_rvalid, if_rdata);
        end
    endtask

    task automatic test_starvation();
        logic exp_if;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) @(negedge clk);
            #1;
`ifdef MEM_ARB_STARVE_GUARD_EN
            exp_if = (c == 5);
`else
            exp_if = 1'b0;
`endif
            $display("[TB] contention cycle %0d: if_gnt=%b dm_gnt=%b", c, if_gnt, dm_gnt);
            tests_run++;
            if (if_gnt !== exp_if || dm_gnt !== ~exp_if) begin
                tests_failed++;
                $display("FAIL starve_c%0d: got if_gnt=%b dm_gnt=%b, want %b %b", c, if_gnt, dm_gnt, exp_if, ~exp_if);
            end
        end
        @(negedge clk);
        if_req = 1'b0; dm_req = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
        #1;
        $display("[TB] load 0x40 then reset");
        tests_run++;
        if (dm_gnt !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_gnt: got dm_gnt=%b, want 1", dm_gnt);
        end
        @(posedge clk); #1;
        rst = 1'b1; dm_req = 1'b0;
        #1;
        tests_run++;
        if (dm_rvalid !== 1'b0 || dm_rdata !== 32'd0 || dm_gnt !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_in: got dm_rvalid=%b dm_rdata=%h dm_gnt=%b, want 0 00000000 0", dm_rvalid, dm_rdata, dm_gnt);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (dm_rvalid !== 1'b0 || if_rvalid !== 1'b0 || dut.resp_state_reg !== RESP_NONE) begin
            tests_failed++;
            $display("FAIL midrst_after: got dm_rvalid=%b if_rvalid=%b state=%0d, want 0 0 %0d",
                     dm_rvalid, if_rvalid, dut.resp_state_reg, RESP_NONE);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i * 4);
        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        test_reset();
        test_store_load();
        test_contention();
        test_back_to_back();
        test_starvation();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
